clk_en_sequencer: RTL
=====================

// Module: clk_en_sequencer
// PURPOSE
//   Staggers the clock-enable lines of N downstream clock domains (core, internal, system ...).
//   - Power-up: enables turn on in ascending index order.
//   - Power-down: enables turn off in descending index order.
//   - Consecutive enable changes are spaced by a fixed gap, limiting di/dt.
//   - Sits between the power/mode controller (up_req/down_req) and the per-domain clock gates.
// PARAMETERS
//   N_DOMAINS   4  number of sequenced domains, legal 2..16
//   GAP_CYCLES  8  clk cycles between consecutive enable changes, legal 1..255
//   CNT_W       localparam $clog2(GAP_CYCLES+1); gap counter width
// PORTS
//   clk        in   1          single clock; all logic on posedge clk
//   rst        in   1          synchronous, active-high reset
//   up_req     in   1          request power-up sequence (level sampled each edge)
//   down_req   in   1          request power-down sequence (level sampled each edge)
//   clk_en     out  N_DOMAINS  per-domain clock enable, registered
//   busy       out  1          high while state is RAMP_UP or RAMP_DOWN
//   up_done    out  1          1-cycle pulse when sequencer enters ON
//   down_done  out  1          1-cycle pulse when sequencer enters OFF from RAMP_DOWN
//   seq_state  out  2          0=OFF 1=RAMP_UP 2=ON 3=RAMP_DOWN
// BEHAVIOUR
//   Reset
//   - clk_en=0, state=OFF, busy=0, up_done=0, down_done=0; gap counter=0, index=0.
//   - Reset asserted mid-ramp: all clk_en drop to 0 after that edge; no done pulse.
//   Notation
//   - All outputs are registered. "After edge t" means the value visible in the following cycle.
//   OFF
//   - up_req=1 at edge t: clk_en[0]=1 after t; state=RAMP_UP; counter=GAP_CYCLES-1.
//   - down_req is ignored in OFF.
//   - up_req and down_req together in OFF: treated as up.
//   RAMP_UP
//   - Counter decrements each cycle.
//   - At counter 0: set the next-higher enable and reload the counter.
//   - So clk_en[i] rises exactly GAP_CYCLES cycles after clk_en[i-1].
//   - The edge that sets clk_en[N-1] also moves state to ON and pulses up_done.
//   ON
//   - All enables are high; up_req is ignored.
//   - down_req=1 at edge t: clk_en[N-1]=0 after t; state=RAMP_DOWN; counter reloaded.
//   RAMP_DOWN
//   - Mirror of RAMP_UP: the highest set enable clears every GAP_CYCLES.
//   - The edge that clears clk_en[0] moves state to OFF and pulses down_done.
//   - up_req is ignored in RAMP_DOWN (no reversal).
//   Abort
//   - down_req=1 during RAMP_UP: on that edge the highest currently set enable clears; state=RAMP_DOWN.
//   - Down-stepping continues from that index with full gap spacing.
//   - up_req and down_req together in RAMP_UP: down wins.
//   Invariant
//   - clk_en is always thermometer-coded (contiguous ones from bit 0).
//   - At most one bit changes per edge.
//   Outputs
//   - busy = (state==RAMP_UP) || (state==RAMP_DOWN), registered with state.
//   - up_done and down_done are never high together.
// CONFIGURATION
//   CLK_SEQ_SKIP_MASK_EN defined
//   - Adds input skip_mask [N_DOMAINS-1:0], latched when a sequence starts (from OFF or ON).
//   - Masked domains are never enabled and are stepped over with no gap consumed.
//   - The gap is measured between consecutive unmasked changes.
//   - Thermometer invariant applies to unmasked bits only.
//   - All bits masked: up_req takes OFF->ON in one edge with an up_done pulse; down_req behaves the same way.
//   CLK_SEQ_SKIP_MASK_EN undefined
//   - No skip_mask port; every domain is sequenced.
// TESTING (N_DOMAINS=4, GAP_CYCLES=8)
//   1 up_req pulse at edge t
//     -> clk_en=0001 after t, 0011 after t+8, 0111 after t+16, 1111 after t+24
//     -> up_done 1 cycle after t+24; busy high after t until t+24
//   2 from ON, down_req at edge u
//     -> clk_en=0111 after u, 0011 after u+8, 0001 after u+16, 0000 after u+24
//     -> down_done pulse after u+24; state=OFF
//   3 abort: up at t, down_req at t+10 (clk_en=0011)
//     -> 0001 after t+10, 0000 after t+18, down_done pulse; no up_done ever
//   4 ignored requests
//     -> up_req in ON: no change
//     -> up_req during RAMP_DOWN: timeline identical to test 2
//     -> up_req and down_req together in OFF: behaves as test 1
//   5 rst=1 at t+12 during ramp-up -> clk_en=0000, seq_state=0, busy=0 after t+12; no done pulses
//   6 [SKIP_MASK_EN] skip_mask=0010, up at t
//     -> 0001 after t, 0101 after t+8, 1101 after t+16
//     -> up_done after t+16

Source files
------------

// File: rtl/clk_en_sequencer.sv
// Staggers per-domain clock enables: ascending on power-up, descending on power-down, GAP_CYCLES apart.
// Optional CLK_SEQ_SKIP_MASK_EN adds a skip_mask input whose masked domains are stepped over.
module clk_en_sequencer #(
  parameter int N_DOMAINS  = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_req,
  input  logic                 down_req,
`ifdef CLK_SEQ_SKIP_MASK_EN
  input  logic [N_DOMAINS-1:0] skip_mask,
`endif
  output logic [N_DOMAINS-1:0] clk_en,
  output logic                 busy,
  output logic                 up_done,
  output logic                 down_done,
  output logic [1:0]           seq_state
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
  localparam int IDX_W = $clog2(N_DOMAINS);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [N_DOMAINS-1:0] clk_en_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic                 busy_n, up_done_n, down_done_n;
  logic                 do_down;

  // mask_start is the mask seen on the edge a sequence begins; mask_q holds it for the ramp
  logic [N_DOMAINS-1:0] mask_start, mask_q;

  function automatic logic free_above_any(input logic [N_DOMAINS-1:0] m, input int lo);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_DOMAINS; i++)
      if (i >= lo && !m[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] free_above_idx(input logic [N_DOMAINS-1:0] m, input int lo);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_DOMAINS - 1; i >= 0; i--)
      if (i >= lo && !m[i]) r = IDX_W'(i);
    return r;
  endfunction

  function automatic logic set_below_any(input logic [N_DOMAINS-1:0] v, input int hi);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_DOMAINS; i++)
      if (i < hi && v[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] set_below_idx(input logic [N_DOMAINS-1:0] v, input int hi);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_DOMAINS; i++)
      if (i < hi && v[i]) r = IDX_W'(i);
    return r;
  endfunction

`ifdef CLK_SEQ_SKIP_MASK_EN
  logic seq_start;
  assign mask_start = skip_mask;
  assign seq_start  = (state == ST_OFF && up_req) || (state == ST_ON && down_req);

  always_ff @(posedge clk) begin
    if (rst)            mask_q <= '0;
    else if (seq_start) mask_q <= skip_mask;
  end
`else
  assign mask_start = '0;
  assign mask_q     = '0;
`endif

  logic             first_any, first_more, next_any, next_more, dn_any;
  logic [IDX_W-1:0] first_idx, next_idx, dn_idx;

  always_comb begin
    first_any  = free_above_any(mask_start, 0);
    first_idx  = free_above_idx(mask_start, 0);
    first_more = free_above_any(mask_start, int'(first_idx) + 1);
    next_any   = free_above_any(mask_q, int'(idx) + 1);
    next_idx   = free_above_idx(mask_q, int'(idx) + 1);
    next_more  = free_above_any(mask_q, int'(next_idx) + 1);
    dn_any     = set_below_any(clk_en, int'(idx));
    dn_idx     = set_below_idx(clk_en, int'(idx));
  end

  always_comb begin
    state_n     = state;
    clk_en_n    = clk_en;
    cnt_n       = cnt;
    idx_n       = idx;
    up_done_n   = 1'b0;
    down_done_n = 1'b0;
    do_down     = 1'b0;

    case (state)
      ST_OFF: begin
        if (up_req) begin
          if (!first_any) begin
            state_n   = ST_ON;
            up_done_n = 1'b1;
            idx_n     = '0;
          end else begin
            clk_en_n[first_idx] = 1'b1;
            idx_n = first_idx;
            cnt_n = GAP_RELOAD;
            if (first_more) state_n = ST_RAMP_UP;
            else begin
              state_n   = ST_ON;
              up_done_n = 1'b1;
            end
          end
        end
      end
      ST_RAMP_UP: begin
        if (down_req) do_down = 1'b1;
        else if (cnt != '0) cnt_n = cnt - 1'b1;
        else if (next_any) begin
          clk_en_n[next_idx] = 1'b1;
          idx_n = next_idx;
          cnt_n = GAP_RELOAD;
          if (!next_more) begin
            state_n   = ST_ON;
            up_done_n = 1'b1;
          end
        end
      end
      ST_ON: begin
        if (down_req) do_down = 1'b1;
      end
      default: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else           do_down = 1'b1;
      end
    endcase

    // idx always points at the highest enable currently set, so a down step clears it
    if (do_down) begin
      if (clk_en == '0) begin
        state_n     = ST_OFF;
        down_done_n = 1'b1;
        idx_n       = '0;
      end else begin
        clk_en_n[idx] = 1'b0;
        cnt_n = GAP_RELOAD;
        if (dn_any) begin
          state_n = ST_RAMP_DOWN;
          idx_n   = dn_idx;
        end else begin
          state_n     = ST_OFF;
          down_done_n = 1'b1;
          idx_n       = '0;
        end
      end
    end

    busy_n = (state_n == ST_RAMP_UP) || (state_n == ST_RAMP_DOWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      clk_en    <= '0;
      cnt       <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      up_done   <= 1'b0;
      down_done <= 1'b0;
    end else begin
      state     <= state_n;
      clk_en    <= clk_en_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      busy      <= busy_n;
      up_done   <= up_done_n;
      down_done <= down_done_n;
    end
  end

  assign seq_state = state;

endmodule
